decoder_4_to_16: RTL and testbench
==================================

# decoder_4_to_16

Binary-to-one-hot decoder: a 4-bit select drives exactly one of 16 output lines high. It provides a zero-latency combinational decode plus a registered, enable-qualified copy with status (valid, change pulse, sticky coverage mask) for synchronous consumers. It is used as the address/chip-select decode stage feeding 16 downstream targets.

## Interface
- SEL_W, 4: select width; fixed at 4 in this block, other values unsupported.
- OUT_W, 16: output width, equals 2**SEL_W.
- clk  input  1  rising-edge clock for all registered outputs.
- rst_n  input  1  synchronous reset, active-low; one clock; reset is synchronous and active-low.
- select  input  4  binary index to decode.
- en  input  1  capture enable for the registered path.
- clear  input  1  synchronous clear of the sticky coverage mask.
- decoded  output  16  combinational one-hot decode of select.
- decoded_q  output  16  registered one-hot decode.
- valid_q  output  1  registered en; high when decoded_q was updated on the last edge.
- changed_q  output  1  one-cycle pulse: captured select differs from previous capture.
- seen_q  output  16  sticky OR of all captured decodes since reset/clear.

## Operation
- decoded = 16'b1 << select, purely combinational, no dependence on clk, rst_n, or en; exactly one bit high for every select value.
- Bit mapping: decoded[k] high iff select == k (select 4'b0000 -> bit 0, 4'b1111 -> bit 15).
- No X propagation handling required beyond standard shift semantics.
- Registered path, on each rising clk:
  - rst_n low: decoded_q = 0, valid_q = 0, changed_q = 0, seen_q = 0, internal last-select = 0, internal first-capture flag set.
  - else if en: decoded_q = 1 << select; valid_q = 1; changed_q = 1 if first capture since reset or select != last-select, else 0; last-select = select; first-capture flag cleared.
  - else: decoded_q holds; valid_q = 0; changed_q = 0.
  - seen_q: if clear, seen_q = 0 (clear takes priority; a simultaneous en capture is NOT merged into seen_q); else if en, seen_q |= 1 << select; else hold.
- decoded_q is either all-zero (only after reset, before first en) or one-hot; never multiple bits.
- clear does not affect decoded_q, valid_q, changed_q, or last-select.

## Timing
- decoded: zero-cycle latency, combinational from select.
- decoded_q, valid_q, changed_q, seen_q: one-cycle latency from en/select sampled at rising clk.
- Reset values: decoded_q 0, valid_q 0, changed_q 0, seen_q 0; decoded follows select even during reset.
- Reset asserted mid-stream: all registered state cleared on that edge regardless of en/clear; next en capture reports changed_q = 1 even if select equals pre-reset value.
- en held high with constant select: changed_q high only on first capture cycle, then 0.
- Back-to-back captures with differing select: changed_q high every cycle.
- Wrap/boundary: select 4'b1111 sets bit 15 only; no carry, no overflow.

## Test plan
- Combinational sweep, no clock needed: select 0000, 0001, 0010, 0011, 0100, 1011, 1111, 0000 -> decoded 0x0001, 0x0002, 0x0004, 0x0008, 0x0010, 0x0800, 0x8000, 0x0001, each settling before next change.
- Exhaustive: all 16 select values -> decoded == 1<<select and popcount(decoded) == 1.
- Reset then en=1 with select 4'b0101 -> after one edge decoded_q 0x0020, valid_q 1, changed_q 1, seen_q 0x0020; hold select two more cycles -> changed_q 0.
- Capture 0000, 1011, 1111 with en each cycle -> seen_q 0x8801; then en=0 -> valid_q 0, decoded_q holds 0x8000.
- clear and en same edge with select 0011 -> seen_q 0x0000, decoded_q 0x0008; next en with 0011 -> seen_q 0x0008, changed_q 0.
- rst_n low for one edge mid-stream with en=1 -> all registered outputs 0 after that edge; next capture of same select -> changed_q 1.

Source files
------------

// File: rtl/decoder_4_to_16.sv
// decoder_4_to_16: binary-to-one-hot decode of a 4-bit select.
// Provides a combinational decode plus a registered, enable-qualified copy with status.
// Ports:
//   clk       - rising-edge clock for all registered outputs
//   rst_n     - synchronous active-low reset
//   select    - binary index to decode
//   en        - capture enable for the registered path
//   clear     - synchronous clear of the sticky coverage mask
//   decoded   - combinational one-hot decode of select
//   decoded_q - registered one-hot decode (all-zero only before the first capture)
//   valid_q   - high when decoded_q was updated on the last edge
//   changed_q - pulse: captured select differs from the previous capture
//   seen_q    - sticky OR of captured decodes since reset/clear
module decoder_4_to_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  select,
  input  logic        en,
  input  logic        clear,
  output logic [15:0] decoded,
  output logic [15:0] decoded_q,
  output logic        valid_q,
  output logic        changed_q,
  output logic [15:0] seen_q
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned OUT_W = 16;

  logic [SEL_W-1:0] last_sel_q;
  logic             first_q;

  // Zero-latency decode, independent of clock, reset and enable.
  always_comb begin
    decoded = OUT_W'(1) << select;
  end

  // Registered capture path and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decoded_q  <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      seen_q     <= '0;
      last_sel_q <= '0;
      first_q    <= 1'b1;
    end else begin
      if (en) begin
        decoded_q  <= decoded;
        valid_q    <= 1'b1;
        // The first capture after reset always counts as a change.
        changed_q  <= first_q || (select != last_sel_q);
        last_sel_q <= select;
        first_q    <= 1'b0;
      end else begin
        valid_q    <= 1'b0;
        changed_q  <= 1'b0;
      end
      // Clear wins over a same-edge capture; that capture is dropped from the mask.
      if (clear) begin
        seen_q <= '0;
      end else if (en) begin
        seen_q <= seen_q | decoded;
      end
    end
  end

endmodule

// File: tb/tb_decoder_4_to_16.sv
// Self-checking bench for decoder_4_to_16: combinational sweeps plus a
// scoreboard of expected registered outputs produced by a bench-side model.
module tb_decoder_4_to_16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  select;
  logic        en;
  logic        clear;
  logic [15:0] decoded;
  logic [15:0] decoded_q;
  logic        valid_q;
  logic        changed_q;
  logic [15:0] seen_q;

  typedef struct {
    logic [15:0] dq;
    logic        v;
    logic        c;
    logic [15:0] seen;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Bench reference state.
  logic [15:0] m_dq;
  logic        m_v;
  logic        m_c;
  logic [15:0] m_seen;
  logic [3:0]  m_last;
  logic        m_first;

  decoder_4_to_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .select    (select),
    .en        (en),
    .clear     (clear),
    .decoded   (decoded),
    .decoded_q (decoded_q),
    .valid_q   (valid_q),
    .changed_q (changed_q),
    .seen_q    (seen_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the model, then compare after the edge.
  task automatic step(input logic r, input logic [3:0] s, input logic e, input logic c);
    exp_t x;
    logic [15:0] oh;
    @(negedge clk);
    rst_n  = r;
    select = s;
    en     = e;
    clear  = c;
    oh = 16'h0001 << s;
    if (!r) begin
      m_dq = '0; m_v = 1'b0; m_c = 1'b0; m_seen = '0; m_last = '0; m_first = 1'b1;
    end else begin
      if (e) begin
        m_c = m_first || (s != m_last);
        m_dq = oh; m_v = 1'b1; m_last = s; m_first = 1'b0;
      end else begin
        m_v = 1'b0; m_c = 1'b0;
      end
      if (c) m_seen = '0;
      else if (e) m_seen = m_seen | oh;
    end
    x.dq = m_dq; x.v = m_v; x.c = m_c; x.seen = m_seen;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("decoded_q", 32'(decoded_q), 32'(x.dq));
      check("valid_q",   32'(valid_q),   32'(x.v));
      check("changed_q", 32'(changed_q), 32'(x.c));
      check("seen_q",    32'(seen_q),    32'(x.seen));
    end
  endtask

  logic [3:0]  sweep_sel [8];
  logic [15:0] sweep_exp [8];

  initial begin
    rst_n = 1'b0; select = '0; en = 1'b0; clear = 1'b0;
    sweep_sel = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hF, 4'h0};
    sweep_exp = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0800, 16'h8000, 16'h0001};

    // Reset values.
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("rst_decoded_q", 32'(decoded_q), 32'h0);
    check("rst_seen_q", 32'(seen_q), 32'h0);

    // Combinational sweep (decode follows select even in reset).
    for (int i = 0; i < 8; i++) begin
      select = sweep_sel[i];
      #1;
      check("sweep", 32'(decoded), 32'(sweep_exp[i]));
    end
    // Exhaustive one-hot check.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] want;
      select = 4'(i);
      want = 16'h0001 << i;
      #1;
      check("exh_decode", 32'(decoded), 32'(want));
      check("exh_popcount", 32'($countones(decoded)), 32'd1);
    end

    // First capture after reset, then hold.
    step(1'b1, 4'h5, 1'b1, 1'b0);
    check("cap5_dq", 32'(decoded_q), 32'h0020);
    check("cap5_chg", 32'(changed_q), 32'd1);
    check("cap5_seen", 32'(seen_q), 32'h0020);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    check("hold5_chg", 32'(changed_q), 32'd0);

    // Coverage mask accumulation, then idle.
    step(1'b1, 4'h5, 1'b0, 1'b1);
    step(1'b1, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'hB, 1'b1, 1'b0);
    step(1'b1, 4'hF, 1'b1, 1'b0);
    check("seen_8801", 32'(seen_q), 32'h8801);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    check("idle_valid", 32'(valid_q), 32'd0);
    check("idle_dq", 32'(decoded_q), 32'h8000);

    // Clear wins over simultaneous capture.
    step(1'b1, 4'h3, 1'b1, 1'b1);
    check("clr_seen", 32'(seen_q), 32'h0);
    check("clr_dq", 32'(decoded_q), 32'h0008);
    step(1'b1, 4'h3, 1'b1, 1'b0);
    check("post_clr_seen", 32'(seen_q), 32'h0008);
    check("post_clr_chg", 32'(changed_q), 32'd0);

    // Mid-stream reset with en high, then same select recaptured.
    step(1'b0, 4'h3, 1'b1, 1'b0);
    check("mrst_dq", 32'(decoded_q), 32'h0);
    check("mrst_valid", 32'(valid_q), 32'd0);
    step(1'b1, 4'h3, 1'b1, 1'b0);
    check("mrst_chg", 32'(changed_q), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
